// File: rtl/fp_operand_loader.sv
// -----------------------------------------------------------------------------
// fp_operand_loader
//   Byte-serial front end for the floating-point add/sub unit. Two operands
//   (A then B, MSB byte first) are assembled from an 8-bit valid/ready stream.
//   The add/sub select is latched with the first byte of a frame. The complete
//   frame {out_a, out_b, out_sub} is presented behind a valid/ready handshake
//   and held stable until downstream accepts it.
//
//   Optional feature macro: FP_LOADER_TIMEOUT_EN
//     When defined, a partial frame that sits idle for TIMEOUT_CYCLES cycles
//     is discarded and frame_err pulses for one cycle. When undefined,
//     frame_err is tied low and a partial frame waits indefinitely.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_data    in   operand byte
//   in_valid   in   in_data valid
//   in_ready   out  loader accepts a byte this cycle (low while presenting)
//   in_sub     in   op select, sampled with the first byte of a frame
//   out_a      out  operand A
//   out_b      out  operand B
//   out_sub    out  op select (1 = A-B)
//   out_valid  out  outputs hold a complete frame
//   out_ready  in   downstream accepts the frame
//   frame_err  out  one-cycle pulse when a partial frame is discarded
// -----------------------------------------------------------------------------
module fp_operand_loader #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err
);

    localparam int BYTES = WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             accept_s;
    logic             last_byte_s;
    logic             abort_s;
    logic             load_a_s;
    logic             load_b_s;
    logic             frame_start_s;
    logic [WIDTH-1:0] out_a_r;
    logic [WIDTH-1:0] out_b_r;
    logic             out_sub_r;
    logic             out_valid_r;

    // Shift one byte in at the LSB end; written without a part-select so
    // WIDTH = 8 stays legal.
    function automatic logic [WIDTH-1:0] shift_byte(input logic [WIDTH-1:0] cur,
                                                    input logic [7:0]       b);
        logic [WIDTH-1:0] t;
        t      = cur << 8;
        t[7:0] = b;
        return t;
    endfunction

    assign in_ready      = (state_r != PRESENT);
    assign accept_s      = in_valid && in_ready;
    assign last_byte_s   = (cnt_r == LAST_BYTE);
    // An abort in the same cycle as an accepted byte drops that byte.
    assign load_a_s      = accept_s && !abort_s && (state_r == LOAD_A);
    assign load_b_s      = accept_s && !abort_s && (state_r == LOAD_B);
    assign frame_start_s = load_a_s && (cnt_r == {CNT_W{1'b0}});

    assign out_a     = out_a_r;
    assign out_b     = out_b_r;
    assign out_sub   = out_sub_r;
    assign out_valid = out_valid_r;

`ifdef FP_LOADER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_r;
    logic              mid_frame_s;
    logic              frame_err_r;

    assign mid_frame_s = (state_r == LOAD_B) ||
                         ((state_r == LOAD_A) && (cnt_r != {CNT_W{1'b0}}));
    // The abort is decided by the registered count alone, so it also wins
    // over a byte arriving in the same cycle.
    assign abort_s     = (idle_r == IDLE_W'(TIMEOUT_CYCLES));
    assign frame_err   = frame_err_r;

    // Idle counter: counts mid-frame cycles without an accepted byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_r      <= {IDLE_W{1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= abort_s;
            if (abort_s || accept_s || !mid_frame_s) begin
                idle_r <= {IDLE_W{1'b0}};
            end else begin
                idle_r <= idle_r + IDLE_W'(1);
            end
        end
    end
`else
    assign abort_s   = 1'b0;
    assign frame_err = 1'b0;
`endif

    // Next-state and byte-counter logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        if (abort_s) begin
            state_next_s = LOAD_A;
            cnt_next_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                LOAD_A: begin
                    if (accept_s) begin
                        if (last_byte_s) begin
                            state_next_s = LOAD_B;
                            cnt_next_s   = {CNT_W{1'b0}};
                        end else begin
                            cnt_next_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                end
                LOAD_B: begin
                    if (accept_s) begin
                        if (last_byte_s) begin
                            state_next_s = PRESENT;
                            cnt_next_s   = {CNT_W{1'b0}};
                        end else begin
                            cnt_next_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        state_next_s = LOAD_A;
                    end else begin
                        state_next_s = PRESENT;
                    end
                end
                default: begin
                    state_next_s = LOAD_A;
                    cnt_next_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, counter and output-valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= LOAD_A;
            cnt_r       <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            out_valid_r <= (state_next_s == PRESENT);
        end
    end

    // Operand shift registers and op-select capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a_r   <= {WIDTH{1'b0}};
            out_b_r   <= {WIDTH{1'b0}};
            out_sub_r <= 1'b0;
        end else begin
            if (load_a_s) begin
                out_a_r <= shift_byte(out_a_r, in_data);
            end
            if (load_b_s) begin
                out_b_r <= shift_byte(out_b_r, in_data);
            end
            if (frame_start_s) begin
                out_sub_r <= in_sub;
            end
        end
    end

endmodule

// File: tb/tb_fp_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_fp_operand_loader
//   Directed, table-driven bench for fp_operand_loader (WIDTH = 32). Frames
//   from a vector table are streamed in and the presented operands compared
//   with the table, followed by hand-written sequences for backpressure,
//   back-to-back frames, mid-frame reset and the idle-timeout behaviour.
// -----------------------------------------------------------------------------
module tb_fp_operand_loader;

`ifdef FP_LOADER_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_sub;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        out_sub;
    logic        out_valid;
    logic        out_ready;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;

    fp_operand_loader #(.WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sub    (in_sub),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_sub   (out_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams one frame; in_sub is correct only on the first byte so that a
    // late capture would be visible.
    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [63:0] w;
        w = {a, b};
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = w[63 - 8*i -: 8];
            in_sub   = (i == 0) ? sub : ~sub;
            tick();
        end
        in_valid = 1'b0;
        in_sub   = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({name, "_wait_valid"}, 32'(ok), 32'd1);
    endtask

    task automatic expect_frame(input string name, input logic [31:0] a,
                                input logic [31:0] b, input logic sub);
        wait_valid(name);
        check({name, "_out_a"},   out_a,        a);
        check({name, "_out_b"},   out_b,        b);
        check({name, "_out_sub"}, 32'(out_sub), 32'(sub));
        if (out_ready) begin
            tick();
            check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
        end
    endtask

    vec_t        vecs [4];
    logic [7:0]  stream [16];
    logic [31:0] va [2];
    logic [31:0] vb [2];
    int          vcyc [2];
    int          nv;
    int          idx;
    int          cyc;
    int          err_cnt;
    int          val_cnt;
    logic        acc;

    initial begin
        vecs[0] = '{sub: 1'b0, a: 32'h4000_0000, b: 32'h4380_0000};
        vecs[1] = '{sub: 1'b1, a: 32'h4200_0040, b: 32'h4200_0040};
        vecs[2] = '{sub: 1'b0, a: 32'hDEAD_BEEF, b: 32'h0123_4567};
        vecs[3] = '{sub: 1'b1, a: 32'h8000_0001, b: 32'h7F7F_FFFF};

        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_out_a",     out_a,             32'h0);
        check("rst_out_b",     out_b,             32'h0);
        check("rst_out_sub",   32'(out_sub),      32'd0);
        check("rst_out_valid", 32'(out_valid),    32'd0);
        check("rst_frame_err", 32'(frame_err),    32'd0);
        check("rst_in_ready",  32'(in_ready),     32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Table-driven frames with downstream always ready.
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].a, vecs[v].b, vecs[v].sub);
            expect_frame($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].sub);
        end

        // Backpressure: frame held while junk bytes are offered.
        out_ready = 1'b0;
        send_frame(32'h3F80_0000, 32'hC020_0000, 1'b1);
        wait_valid("bp");
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_out_a",     out_a,          32'h3F80_0000);
            check("bp_out_b",     out_b,          32'hC020_0000);
            check("bp_out_sub",   32'(out_sub),   32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_handoff_valid", 32'(out_valid), 32'd0);
        check("bp_handoff_ready", 32'(in_ready),  32'd1);
        send_frame(32'h1357_9BDF, 32'h2468_ACE0, 1'b0);
        expect_frame("bp_next", 32'h1357_9BDF, 32'h2468_ACE0, 1'b0);

        // Back-to-back frames with in_valid held high.
        {stream[0], stream[1], stream[2], stream[3]}     = 32'hA1B2_C3D4;
        {stream[4], stream[5], stream[6], stream[7]}     = 32'h0102_0304;
        {stream[8], stream[9], stream[10], stream[11]}   = 32'hCAFE_F00D;
        {stream[12], stream[13], stream[14], stream[15]} = 32'h5566_7788;
        nv  = 0;
        idx = 0;
        cyc = 0;
        while (cyc < 40) begin
            in_valid = (idx < 16);
            in_data  = (idx < 16) ? stream[idx] : 8'h00;
            acc      = in_ready && (idx < 16);
            tick();
            cyc++;
            if (acc) idx++;
            if (out_valid && nv < 2) begin
                vcyc[nv] = cyc;
                va[nv]   = out_a;
                vb[nv]   = out_b;
                nv++;
            end
            if (nv == 2) break;
        end
        in_valid = 1'b0;
        check("b2b_pulses", 32'(nv), 32'd2);
        if (nv == 2) begin
            check("b2b_spacing", 32'(vcyc[1] - vcyc[0]), 32'd9);
            check("b2b_a0", va[0], 32'hA1B2_C3D4);
            check("b2b_b0", vb[0], 32'h0102_0304);
            check("b2b_a1", va[1], 32'hCAFE_F00D);
            check("b2b_b1", vb[1], 32'h5566_7788);
        end
        tick();

        // Reset after three A bytes.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hAA + 8'(i);
            in_sub   = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        check("mrst_out_a",     out_a,          32'h0);
        check("mrst_out_b",     out_b,          32'h0);
        check("mrst_out_sub",   32'(out_sub),   32'd0);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        send_frame(32'h3F80_0000, 32'h3F80_0000, 1'b0);
        expect_frame("mrst_next", 32'h3F80_0000, 32'h3F80_0000, 1'b0);

        // Idle in the middle of operand B.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h11 * 8'(i + 1);
            in_sub   = (i == 0);
            tick();
        end
        in_valid = 1'b0;
        in_sub   = 1'b0;
        err_cnt  = 0;
        val_cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            if (frame_err) err_cnt++;
            if (out_valid) val_cnt++;
            tick();
        end
        check("idle_no_valid", 32'(val_cnt), 32'd0);
`ifdef FP_LOADER_TIMEOUT_EN
        check("to_err_pulses", 32'(err_cnt), 32'd1);
        check("to_ready_after", 32'(in_ready), 32'd1);
        send_frame(32'h3C00_0000, 32'hBF80_0000, 1'b1);
        expect_frame("to_next", 32'h3C00_0000, 32'hBF80_0000, 1'b1);
`else
        check("noto_err_pulses", 32'(err_cnt), 32'd0);
        for (int i = 5; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h11 * 8'(i + 1);
            in_sub   = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        expect_frame("noto_resume", 32'h1122_3344, 32'h5566_7788, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
